debounced_input_pio: RTL and testbench

// Parametrised successor to the push-button PIO: a WIDTH-bit Avalon-MM input port

---
 rtl/debounced_input_pio.sv | 121 ++++++++++++
 tb/tb_debounced_input_pio.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounced_input_pio.sv
// Debounced WIDTH-bit Avalon-MM input port: 2-flop sync, counter debounce,
// per-bit rising/falling edge select, W1C edge capture and a masked level irq.
module debounced_input_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd4;
  localparam logic [2:0] ADDR_RAW      = 3'd5;

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [31:0]      readdata_q, readdata_d;

  logic             wr_en;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] clr_mask;

  assign wr_en = chipselect & ~write_n;

  // Per-bit debounce: count while synced input differs from stable, accept at the limit.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    stable_d = stable_q;
    edge_evt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = s2_q[i];
          edge_evt[i] = s2_q[i] ? rise_en_q[i] : fall_en_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Register writes, W1C edge capture (new event beats a same-cycle clear) and read mux.
  always_comb begin
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    irq_mask_d = irq_mask_q;
    clr_mask   = '0;
    if (wr_en) begin
      case (address)
        ADDR_RISE_EN:  rise_en_d  = writedata[WIDTH-1:0];
        ADDR_IRQ_MASK: irq_mask_d = writedata[WIDTH-1:0];
        ADDR_EDGE_CAP: clr_mask   = writedata[WIDTH-1:0];
        ADDR_FALL_EN:  fall_en_d  = writedata[WIDTH-1:0];
        default:       ;
      endcase
    end
    edge_cap_d = (edge_cap_q & ~clr_mask) | edge_evt;

    readdata_d = '0;
    case (address)
      ADDR_DATA:     readdata_d[WIDTH-1:0] = stable_q;
      ADDR_RISE_EN:  readdata_d[WIDTH-1:0] = rise_en_q;
      ADDR_IRQ_MASK: readdata_d[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGE_CAP: readdata_d[WIDTH-1:0] = edge_cap_q;
      ADDR_FALL_EN:  readdata_d[WIDTH-1:0] = fall_en_q;
      ADDR_RAW:      readdata_d[WIDTH-1:0] = s2_q;
      default:       ;
    endcase
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      stable_q   <= '0;
      // NOTE: the counter array is small flop storage, not RAM, so it is reset to drop any partial count.
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      readdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      s1_q       <= in_port;
      s2_q       <= s1_q;
      stable_q   <= stable_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_debounced_input_pio.sv
// Directed bench for debounced_input_pio with WIDTH=4, DEBOUNCE_CYCLES=4.
module tb_debounced_input_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  debounced_input_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // One clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle();
    tick(8);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    in_port = 4'hF;
    address = 3'd0;
    tick(3);
    checks++;
    if (readdata !== 32'h0) begin failures++; $display("FAIL reset_readdata got=%h exp=%h", readdata, 32'h0); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    reset = 1'b0;
    tick(6);
    // stable updated on edge 6; readdata shows it one edge later
    checks++;
    if (readdata !== 32'h0) begin failures++; $display("FAIL reset_data_early got=%h exp=%h", readdata, 32'h0); end
    tick();
    checks++;
    if (readdata !== 32'hF) begin failures++; $display("FAIL reset_data_after6 got=%h exp=%h", readdata, 32'hF); end
    rd(3'd3, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_edge_cap got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_debounce();
    logic [31:0] d;
    wr(3'd1, 32'h1);
    wr(3'd2, 32'h1);
    in_port = 4'hE;
    settle();
    address = 3'd0;
    in_port = 4'hF;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i <= 5) begin
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL deb_irq_early clk=%0d got=%b exp=0", i, irq); end
      end
      if (i == 6) begin
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL deb_irq_clk6 got=%b exp=1", irq); end
        checks++;
        if (readdata[0] !== 1'b0) begin failures++; $display("FAIL deb_data_clk6 got=%b exp=0", readdata[0]); end
      end
      if (i == 7) begin
        checks++;
        if (readdata !== 32'hF) begin failures++; $display("FAIL deb_data_clk7 got=%h exp=%h", readdata, 32'hF); end
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL deb_irq_clk7 got=%b exp=1", irq); end
      end
    end
    rd(3'd3, d);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL deb_edge_cap got=%h exp=%h", d, 32'h1); end
    // 3-clock glitch on bit 0 must be rejected
    wr(3'd3, 32'h1);
    in_port = 4'hE;
    settle();
    in_port = 4'hF;
    tick(3);
    in_port = 4'hE;
    settle();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL glitch_irq got=%b exp=0", irq); end
    rd(3'd0, d);
    checks++;
    if (d !== 32'hE) begin failures++; $display("FAIL glitch_data got=%h exp=%h", d, 32'hE); end
    rd(3'd3, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL glitch_edge_cap got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_edge_modes();
    logic [31:0] d;
    in_port = 4'hF;
    settle();
    wr(3'd1, 32'h0);
    wr(3'd4, 32'h2);
    wr(3'd3, 32'hF);
    in_port = 4'hD;
    settle();
    rd(3'd3, d);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL fall_bit1 got=%h exp=%h", d, 32'h2); end
    in_port = 4'hF;
    settle();
    rd(3'd3, d);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL rise_bit1_ignored got=%h exp=%h", d, 32'h2); end
    wr(3'd1, 32'h4);
    wr(3'd4, 32'h4);
    wr(3'd3, 32'hF);
    in_port = 4'hB;
    settle();
    rd(3'd3, d);
    checks++;
    if (d !== 32'h4) begin failures++; $display("FAIL both_fall_bit2 got=%h exp=%h", d, 32'h4); end
    wr(3'd3, 32'h4);
    rd(3'd3, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL both_clear got=%h exp=%h", d, 32'h0); end
    in_port = 4'hF;
    settle();
    rd(3'd3, d);
    checks++;
    if (d !== 32'h4) begin failures++; $display("FAIL both_rise_bit2 got=%h exp=%h", d, 32'h4); end
  endtask

  task automatic test_w1c();
    logic [31:0] d;
    wr(3'd1, 32'h3);
    wr(3'd4, 32'h0);
    wr(3'd2, 32'h0);
    wr(3'd3, 32'hF);
    in_port = 4'hC;
    settle();
    in_port = 4'hF;
    settle();
    rd(3'd3, d);
    checks++;
    if (d !== 32'h3) begin failures++; $display("FAIL w1c_setup got=%h exp=%h", d, 32'h3); end
    wr(3'd2, 32'h1);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL w1c_irq_mask1 got=%b exp=1", irq); end
    wr(3'd3, 32'h1);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL w1c_irq_after_clear got=%b exp=0", irq); end
    rd(3'd3, d);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL w1c_clear_bit0 got=%h exp=%h", d, 32'h2); end
    wr(3'd2, 32'h2);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL w1c_irq_mask2 got=%b exp=1", irq); end
    // clear bit1 on the very edge its new rising event lands
    wr(3'd3, 32'h2);
    in_port = 4'hD;
    settle();
    in_port = 4'hF;
    tick(5);
    wr(3'd3, 32'h2);
    rd(3'd3, d);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL w1c_event_wins got=%h exp=%h", d, 32'h2); end
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL w1c_event_wins_irq got=%b exp=1", irq); end
  endtask

  task automatic test_readback();
    logic [31:0] d;
    wr(3'd1, 32'hFFFF_FFFF);
    rd(3'd1, d);
    checks++;
    if (d !== 32'hF) begin failures++; $display("FAIL rb_rise_en got=%h exp=%h", d, 32'hF); end
    wr(3'd2, 32'hFFFF_FFFF);
    rd(3'd2, d);
    checks++;
    if (d !== 32'hF) begin failures++; $display("FAIL rb_irq_mask got=%h exp=%h", d, 32'hF); end
    wr(3'd4, 32'hFFFF_FFFF);
    rd(3'd4, d);
    checks++;
    if (d !== 32'hF) begin failures++; $display("FAIL rb_fall_en got=%h exp=%h", d, 32'hF); end
    // raw register follows s2 after the two sync flops, no debounce
    address = 3'd5;
    in_port = 4'h5;
    tick(3);
    checks++;
    if (readdata !== 32'h5) begin failures++; $display("FAIL rb_raw got=%h exp=%h", readdata, 32'h5); end
    rd(3'd0, d);
    checks++;
    if (d !== 32'hF) begin failures++; $display("FAIL rb_data_not_yet got=%h exp=%h", d, 32'hF); end
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL rb_addr6 got=%h exp=%h", d, 32'h0); end
    rd(3'd7, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL rb_addr7 got=%h exp=%h", d, 32'h0); end
    // reset in the middle of a debounce count
    settle();
    wr(3'd3, 32'hF);
    in_port = 4'hA;
    tick(4);
    reset = 1'b1;
    tick(2);
    checks++;
    if (readdata !== 32'h0) begin failures++; $display("FAIL rst_mid_readdata got=%h exp=%h", readdata, 32'h0); end
    reset = 1'b0;
    settle();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL rst_mid_irq got=%b exp=0", irq); end
    rd(3'd3, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL rst_mid_edge_cap got=%h exp=%h", d, 32'h0); end
    rd(3'd0, d);
    checks++;
    if (d !== 32'hA) begin failures++; $display("FAIL rst_mid_data got=%h exp=%h", d, 32'hA); end
  endtask

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    test_reset();
    test_debounce();
    test_edge_modes();
    test_w1c();
    test_readback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
